bsg_async_ptr_gray_rx: RTL and testbench



---
 rtl/bsg_async_ptr_pkg.sv | 17 +
 rtl/bsg_gray_to_binary.sv | 18 +
 rtl/bsg_async_ptr_gray_rx.sv | 82 ++++++++
 tb/tb_bsg_async_ptr_gray_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bsg_async_ptr_pkg.sv
// Shared constants and helpers for the async FIFO receive pointer logic.
// Build option: define BSG_ASYNC_PTR_GRAY_RX_SYNC3_EN for a 3-flop
// synchronizer; otherwise the synchronizer is 2 flops deep.
package bsg_async_ptr_pkg;

`ifdef BSG_ASYNC_PTR_GRAY_RX_SYNC3_EN
  localparam int sync_depth_lp = 3;
`else
  localparam int sync_depth_lp = 2;
`endif

  // Binary to reflected Gray code; callers truncate to their pointer width.
  function automatic logic [31:0] bin_to_gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/bsg_gray_to_binary.sv
// Combinational reflected-Gray to binary conversion.
// Each binary bit is the XOR of all Gray bits at and above its position.
module bsg_gray_to_binary #(
  parameter int width_p = 5
) (
  input  logic [width_p-1:0] gray_i,
  output logic [width_p-1:0] binary_o
);

  // Prefix XOR from the MSB down, written as a reduction of the shifted word.
  always_comb begin
    binary_o = '0;
    for (int i = 0; i < width_p; i++) begin
      binary_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/bsg_async_ptr_gray_rx.sv
// Reader-domain pointer logic for an asynchronous FIFO.
// Synchronizes the writer's Gray pointer, converts it to binary, and
// compares it with the local read pointer to produce occupancy and valid.
// Build option: BSG_ASYNC_PTR_GRAY_RX_SYNC3_EN selects a 3-flop synchronizer.
//
// Dequeue handshake: deq_v_o is high whenever an element is readable at
// r_addr_o; deq_yumi_i pulses high in a cycle where deq_v_o is high to take
// that element, and the read pointer advances on that clock edge. A yumi
// while deq_v_o is low is ignored.
module bsg_async_ptr_gray_rx
  import bsg_async_ptr_pkg::*;
#(
  parameter int lg_size_p = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [lg_size_p:0]   w_ptr_gray_i,
  output logic                 deq_v_o,
  input  logic                 deq_yumi_i,
  output logic [lg_size_p-1:0] r_addr_o,
  output logic [lg_size_p:0]   r_ptr_gray_o,
  output logic [lg_size_p:0]   count_o
);

  localparam int ptr_w_lp = lg_size_p + 1;

  logic [ptr_w_lp-1:0] sync_d [sync_depth_lp];
  logic [ptr_w_lp-1:0] sync_q [sync_depth_lp];
  logic [ptr_w_lp-1:0] w_ptr_bin;
  logic [ptr_w_lp-1:0] r_ptr_bin_d, r_ptr_bin_q;
  logic [ptr_w_lp-1:0] r_ptr_gray_d, r_ptr_gray_q;
  logic [ptr_w_lp-1:0] count;
  logic                deq_fire;

  // Plain flop chain for the asynchronous Gray pointer; no logic between stages.
  always_comb begin
    sync_d[0] = w_ptr_gray_i;
    for (int i = 1; i < sync_depth_lp; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  bsg_gray_to_binary #(
    .width_p (ptr_w_lp)
  ) u_g2b (
    .gray_i   (sync_q[sync_depth_lp-1]),
    .binary_o (w_ptr_bin)
  );

  // Occupancy by modular subtraction, valid, and next read pointer values.
  // The Gray read pointer is computed from the next binary value so that the
  // value sent to the writer domain comes straight from a flop.
  always_comb begin
    count        = w_ptr_bin - r_ptr_bin_q;
    deq_fire     = (count != '0) & deq_yumi_i;
    r_ptr_bin_d  = r_ptr_bin_q + {{lg_size_p{1'b0}}, deq_fire};
    r_ptr_gray_d = ptr_w_lp'(bin_to_gray(32'(r_ptr_bin_d)));
  end

  // Synchronizer and read-pointer registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < sync_depth_lp; i++) begin
        sync_q[i] <= '0;
      end
      r_ptr_bin_q  <= '0;
      r_ptr_gray_q <= '0;
    end else begin
      for (int i = 0; i < sync_depth_lp; i++) begin
        sync_q[i] <= sync_d[i];
      end
      r_ptr_bin_q  <= r_ptr_bin_d;
      r_ptr_gray_q <= r_ptr_gray_d;
    end
  end

  assign count_o      = count;
  assign deq_v_o      = (count != '0);
  assign r_addr_o     = r_ptr_bin_q[lg_size_p-1:0];
  assign r_ptr_gray_o = r_ptr_gray_q;

endmodule

// File: tb/tb_bsg_async_ptr_gray_rx.sv
// Directed bench for bsg_async_ptr_gray_rx with lg_size_p = 4.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_bsg_async_ptr_gray_rx;

`ifdef BSG_ASYNC_PTR_GRAY_RX_SYNC3_EN
  localparam int depth = 3;
`else
  localparam int depth = 2;
`endif

  logic       clk_i;
  logic       reset_n_i;
  logic [4:0] w_ptr_gray_i;
  logic       deq_v_o;
  logic       deq_yumi_i;
  logic [3:0] r_addr_o;
  logic [4:0] r_ptr_gray_o;
  logic [4:0] count_o;

  int n_cmp;
  int n_fail;

  bsg_async_ptr_gray_rx #(
    .lg_size_p (4)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .w_ptr_gray_i (w_ptr_gray_i),
    .deq_v_o      (deq_v_o),
    .deq_yumi_i   (deq_yumi_i),
    .r_addr_o     (r_addr_o),
    .r_ptr_gray_o (r_ptr_gray_o),
    .count_o      (count_o)
  );

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic set_w(input int b);
    w_ptr_gray_i = gray5(b);
  endtask

  task automatic do_reset(input int w_bin);
    reset_n_i    = 1'b0;
    deq_yumi_i   = 1'b0;
    set_w(w_bin);
    #3;
    reset_n_i    = 1'b1;
    tick();
  endtask

  // checking
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_v"},     32'(deq_v_o),      0);
    check_eq({tag, "_count"}, 32'(count_o),      0);
    check_eq({tag, "_addr"},  32'(r_addr_o),     0);
    check_eq({tag, "_gray"},  32'(r_ptr_gray_o), 0);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    // Reset with a nonzero writer pointer: everything stays at zero.
    reset_n_i    = 1'b0;
    deq_yumi_i   = 1'b0;
    w_ptr_gray_i = 5'b00011;
    #12;
    check_zero_outputs("rst");
    reset_n_i = 1'b1;
    for (int i = 0; i < depth - 1; i++) begin
      tick();
      check_eq("rst_sync_lat", 32'(count_o), 0);
    end
    tick();
    check_eq("rst_capture_count", 32'(count_o), 2);
    check_eq("rst_capture_v",     32'(deq_v_o), 1);

    // Single element: visible after edge depth-1, removed by one yumi.
    do_reset(0);
    set_w(1);
    for (int i = 0; i < depth - 1; i++) begin
      tick();
      check_eq("single_early_v", 32'(deq_v_o), 0);
    end
    tick();
    check_eq("single_v",     32'(deq_v_o), 1);
    check_eq("single_count", 32'(count_o), 1);
    deq_yumi_i = 1'b1;
    tick();
    deq_yumi_i = 1'b0;
    check_eq("single_deq_v",    32'(deq_v_o),      0);
    check_eq("single_deq_addr", 32'(r_addr_o),     1);
    check_eq("single_deq_gray", 32'(r_ptr_gray_o), 32'h01);

    // Yumi while empty is ignored.
    deq_yumi_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("illegal_addr",  32'(r_addr_o),     1);
      check_eq("illegal_gray",  32'(r_ptr_gray_o), 32'h01);
      check_eq("illegal_count", 32'(count_o),      0);
    end
    deq_yumi_i = 1'b0;

    // Fill to 16, then drain with 16 back-to-back yumis.
    do_reset(0);
    for (int b = 1; b <= 16; b++) begin
      set_w(b);
      tick();
    end
    repeat (depth) tick();
    check_eq("full_count", 32'(count_o), 16);
    check_eq("full_v",     32'(deq_v_o), 1);
    deq_yumi_i = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check_eq("drain_addr",  32'(r_addr_o), 32'(i % 16));
      check_eq("drain_count", 32'(count_o),  32'(16 - i));
    end
    deq_yumi_i = 1'b0;
    check_eq("drain_gray", 32'(r_ptr_gray_o), 32'h18);
    check_eq("drain_v",    32'(deq_v_o),      0);

    // Pointer wrap past 31 -> 0 with occupancy kept across it.
    for (int b = 17; b <= 26; b++) begin
      set_w(b);
      tick();
    end
    repeat (depth) tick();
    check_eq("pre_wrap_count", 32'(count_o), 10);
    deq_yumi_i = 1'b1;
    repeat (10) tick();
    deq_yumi_i = 1'b0;
    check_eq("pre_wrap_addr", 32'(r_addr_o), 10);
    for (int b = 27; b <= 34; b++) begin
      set_w(b % 32);
      tick();
    end
    repeat (depth) tick();
    check_eq("wrap_count", 32'(count_o), 8);
    deq_yumi_i = 1'b1;
    repeat (8) tick();
    deq_yumi_i = 1'b0;
    check_eq("wrap_addr",  32'(r_addr_o),     2);
    check_eq("wrap_gray",  32'(r_ptr_gray_o), 32'h03);
    check_eq("wrap_count0", 32'(count_o),     0);

    // New write reaching the last stage on the same edge as a yumi.
    set_w(3);
    tick();
    repeat (depth) tick();
    check_eq("simul_pre_count", 32'(count_o), 1);
    set_w(4);
    repeat (depth - 1) tick();
    check_eq("simul_hold_count", 32'(count_o), 1);
    deq_yumi_i = 1'b1;
    tick();
    deq_yumi_i = 1'b0;
    check_eq("simul_count", 32'(count_o),  1);
    check_eq("simul_addr",  32'(r_addr_o), 3);

    // Asynchronous reset in the middle of operation.
    for (int b = 5; b <= 8; b++) begin
      set_w(b);
      tick();
    end
    repeat (depth) tick();
    check_eq("mid_count", 32'(count_o), 5);
    #2;
    reset_n_i = 1'b0;
    #1;
    check_zero_outputs("mid_rst");
    #1;
    reset_n_i = 1'b1;
    repeat (depth) tick();
    check_eq("post_rst_count", 32'(count_o), 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
